// File: rtl/pc_next_ctrl_if.sv
// Bundle between the pipeline datapath and the next-PC controller.
// slave is the controller side; master is the datapath/environment side.
interface pc_next_ctrl_if;
    logic [31:0] pc;
    logic        stall;
    logic [31:0] id_pc;
    logic        id_jump;
    logic [25:0] id_jump_target;
    logic        id_jr;
    logic [31:0] id_jr_addr;
    logic        id_illop;
    logic        ex_branch_taken;
    logic [31:0] ex_branch_target;
    logic        irq;
    logic [31:0] pc_in;
    logic        pc_wr;
    logic        flush_if;
    logic        flush_id;
    logic [31:0] epc;
    logic [1:0]  exc_cause;

    modport slave (
        input  pc, stall, id_pc, id_jump, id_jump_target, id_jr, id_jr_addr,
               id_illop, ex_branch_taken, ex_branch_target, irq,
        output pc_in, pc_wr, flush_if, flush_id, epc, exc_cause
    );

    modport master (
        output pc, stall, id_pc, id_jump, id_jump_target, id_jr, id_jr_addr,
               id_illop, ex_branch_taken, ex_branch_target, irq,
        input  pc_in, pc_wr, flush_if, flush_id, epc, exc_cause
    );
endinterface

// File: rtl/pc_next_ctrl.sv
// Next-PC select, stall hold, IF/ID flush and trap entry (EPC/cause) for the pipeline.
// pc_in/pc_wr/flush are same-cycle combinational; epc/exc_cause update on the trap edge.
module pc_next_ctrl #(
    parameter logic [31:0] ILLOP_ADDR = 32'h80000004,
    parameter logic [31:0] XADR_ADDR  = 32'h80000008,
    parameter int          IRQ_SYNC   = 2
) (
    input  logic           clk,
    input  logic           reset,
    pc_next_ctrl_if.slave  bus
);

    typedef enum logic {RUN, FLUSH} state_t;

    state_t                state_q, state_d;
    logic [IRQ_SYNC-1:0]   sync_q;
    logic                  irq_dly_q;
    logic                  irq_pend_q, irq_pend_d;
    logic [31:0]           epc_q, epc_d;
    logic [1:0]            cause_q, cause_d;

    logic [31:0] seq;
    logic        irq_s;
    logic        irq_edge;
    logic        in_run;
    logic        take_ill;
    logic        take_irq;
    logic        unused_bits;

    assign unused_bits = bus.ex_branch_target[31];

    // Low 31 bits wrap; the kernel bit is never touched by the increment.
    assign seq      = {bus.pc[31], bus.pc[30:0] + 31'd4};
    assign irq_s    = sync_q[IRQ_SYNC-1];
    assign irq_edge = irq_s & ~irq_dly_q;
    assign in_run   = (state_q == RUN);

    assign take_ill = reset & ~bus.ex_branch_taken & bus.id_illop & in_run;
    assign take_irq = reset & ~bus.ex_branch_taken & ~take_ill & irq_pend_q
                      & ~bus.pc[31] & in_run & ~bus.stall & ~bus.id_jump & ~bus.id_jr;

    always_comb begin
        bus.pc_in    = seq;
        bus.pc_wr    = 1'b1;
        bus.flush_if = 1'b0;
        bus.flush_id = 1'b0;
        if (!reset) begin
            bus.pc_wr    = 1'b0;
            bus.flush_if = 1'b1;
            bus.flush_id = 1'b1;
        end else if (bus.ex_branch_taken) begin
            bus.pc_in    = {bus.pc[31], bus.ex_branch_target[30:0]};
            bus.flush_if = 1'b1;
            bus.flush_id = 1'b1;
        end else if (take_ill) begin
            bus.pc_in    = ILLOP_ADDR;
            bus.flush_if = 1'b1;
            bus.flush_id = 1'b1;
        end else if (take_irq) begin
            // ID instruction is allowed to retire, so only IF is bubbled.
            bus.pc_in    = XADR_ADDR;
            bus.flush_if = 1'b1;
        end else if (bus.id_jump && !bus.stall) begin
            bus.pc_in    = {bus.id_pc[31:28], bus.id_jump_target, 2'b00};
            bus.flush_if = 1'b1;
        end else if (bus.id_jr && !bus.stall) begin
            bus.pc_in    = {bus.pc[31] & bus.id_jr_addr[31], bus.id_jr_addr[30:0]};
            bus.flush_if = 1'b1;
        end else if (bus.stall) begin
            bus.pc_wr    = 1'b0;
            bus.flush_id = 1'b1;
        end
    end

    always_comb begin
        state_d    = RUN;
        epc_d      = epc_q;
        cause_d    = cause_q;
        irq_pend_d = irq_pend_q | irq_edge;
        if (take_ill) begin
            state_d = FLUSH;
            epc_d   = bus.id_pc;
            cause_d = 2'b01;
        end else if (take_irq) begin
            state_d    = FLUSH;
            epc_d      = bus.pc;
            cause_d    = 2'b10;
            irq_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= RUN;
            sync_q     <= '0;
            irq_dly_q  <= 1'b0;
            irq_pend_q <= 1'b0;
            epc_q      <= '0;
            cause_q    <= 2'b00;
        end else begin
            state_q    <= state_d;
            sync_q     <= {sync_q[IRQ_SYNC-2:0], bus.irq};
            irq_dly_q  <= irq_s;
            irq_pend_q <= irq_pend_d;
            epc_q      <= epc_d;
            cause_q    <= cause_d;
        end
    end

    assign bus.epc       = epc_q;
    assign bus.exc_cause = cause_q;

endmodule

// File: tb/tb_pc_next_ctrl.sv
module tb_pc_next_ctrl;
    localparam logic [31:0] ILLOP = 32'h80000004;
    localparam logic [31:0] XADR  = 32'h80000008;
    localparam int          SYNC  = 2;

    logic clk;
    logic reset;
    pc_next_ctrl_if bus();

    pc_next_ctrl #(.ILLOP_ADDR(ILLOP), .XADR_ADDR(XADR), .IRQ_SYNC(SYNC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        stall;
        logic [31:0] id_pc;
        logic        jump;
        logic [25:0] tgt;
        logic        jr;
        logic [31:0] jr_addr;
        logic        illop;
        logic        br;
        logic [31:0] br_tgt;
        logic [31:0] e_pc_in;
        logic        e_wr;
        logic        e_fif;
        logic        e_fid;
    } vec_t;

    typedef struct {
        logic [31:0] pc_in;
        logic        wr;
        logic        fif;
        logic        fid;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[13];
    int   checks   = 0;
    int   failures = 0;

    function automatic vec_t mk(input logic [31:0] pc, input logic stall,
                                input logic [31:0] id_pc, input logic jump,
                                input logic [25:0] tgt, input logic jr,
                                input logic [31:0] jr_addr, input logic illop,
                                input logic br, input logic [31:0] br_tgt,
                                input logic [31:0] e_pc_in, input logic e_wr,
                                input logic e_fif, input logic e_fid);
        vec_t v;
        v.pc = pc; v.stall = stall; v.id_pc = id_pc; v.jump = jump; v.tgt = tgt;
        v.jr = jr; v.jr_addr = jr_addr; v.illop = illop; v.br = br; v.br_tgt = br_tgt;
        v.e_pc_in = e_pc_in; v.e_wr = e_wr; v.e_fif = e_fif; v.e_fid = e_fid;
        return v;
    endfunction

    function automatic vec_t idle(input logic [31:0] pc);
        return mk(pc, 0, 32'h0, 0, 26'h0, 0, 32'h0, 0, 0, 32'h0,
                  {pc[31], pc[30:0] + 31'd4}, 1, 0, 0);
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        exp_t e;
        bus.pc               = v.pc;
        bus.stall            = v.stall;
        bus.id_pc            = v.id_pc;
        bus.id_jump          = v.jump;
        bus.id_jump_target   = v.tgt;
        bus.id_jr            = v.jr;
        bus.id_jr_addr       = v.jr_addr;
        bus.id_illop         = v.illop;
        bus.ex_branch_taken  = v.br;
        bus.ex_branch_target = v.br_tgt;
        e.pc_in = v.e_pc_in; e.wr = v.e_wr; e.fif = v.e_fif; e.fid = v.e_fid;
        sb.push_back(e);
    endtask

    task automatic check_out(input string nm);
        exp_t e;
        #2;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: scoreboard empty", nm);
        end else begin
            e = sb.pop_front();
            chk({nm, ".pc_in"}, bus.pc_in, e.pc_in);
            chk({nm, ".pc_wr"}, {31'd0, bus.pc_wr}, {31'd0, e.wr});
            chk({nm, ".flush_if"}, {31'd0, bus.flush_if}, {31'd0, e.fif});
            chk({nm, ".flush_id"}, {31'd0, bus.flush_id}, {31'd0, e.fid});
        end
    endtask

    task automatic check_reg(input string nm, input logic [31:0] epc, input logic [1:0] cause);
        chk({nm, ".epc"}, bus.epc, epc);
        chk({nm, ".exc_cause"}, {30'd0, bus.exc_cause}, {30'd0, cause});
    endtask

    task automatic step(input vec_t v, input string nm);
        @(negedge clk);
        apply(v);
        check_out(nm);
    endtask

    initial begin
        int taken_at;
        vec_t rst_v;

        //           pc            st id_pc        jmp tgt        jr jr_addr       ill br br_tgt         exp_pc_in     wr fif fid
        tbl[0]  = mk(32'h00000000, 0, 32'h0,       0, 26'h0,     0, 32'h0,        0, 0, 32'h0,        32'h00000004, 1, 0, 0);
        tbl[1]  = mk(32'h7FFFFFFC, 0, 32'h0,       0, 26'h0,     0, 32'h0,        0, 0, 32'h0,        32'h00000000, 1, 0, 0);
        tbl[2]  = mk(32'h80000010, 0, 32'h0,       0, 26'h0,     0, 32'h0,        0, 0, 32'h0,        32'h80000014, 1, 0, 0);
        tbl[3]  = mk(32'h00000020, 0, 32'h1C,      0, 26'h0,     0, 32'h0,        1, 1, 32'h00000100, 32'h00000100, 1, 1, 1);
        tbl[4]  = mk(32'h00000020, 0, 32'h1C,      0, 26'h0,     0, 32'h0,        0, 1, 32'h80000100, 32'h00000100, 1, 1, 1);
        tbl[5]  = mk(32'h80000020, 0, 32'h1C,      0, 26'h0,     0, 32'h0,        0, 1, 32'h00000300, 32'h80000300, 1, 1, 1);
        tbl[6]  = mk(32'h00000044, 0, 32'h30000040, 1, 26'h123,  0, 32'h0,        0, 0, 32'h0,        32'h3000048C, 1, 1, 0);
        tbl[7]  = mk(32'h00000040, 1, 32'h30000040, 1, 26'h123,  0, 32'h0,        0, 0, 32'h0,        32'h00000044, 0, 0, 1);
        tbl[8]  = mk(32'h00000050, 1, 32'h4C,      0, 26'h0,     1, 32'h80001000, 0, 0, 32'h0,        32'h00000054, 0, 0, 1);
        tbl[9]  = mk(32'h00000050, 0, 32'h4C,      0, 26'h0,     1, 32'h80001000, 0, 0, 32'h0,        32'h00001000, 1, 1, 0);
        tbl[10] = mk(32'h80000050, 0, 32'h4C,      0, 26'h0,     1, 32'h80001000, 0, 0, 32'h0,        32'h80001000, 1, 1, 0);
        tbl[11] = mk(32'h80000050, 0, 32'h4C,      0, 26'h0,     1, 32'h00002000, 0, 0, 32'h0,        32'h00002000, 1, 1, 0);
        tbl[12] = mk(32'h00000100, 1, 32'h0,       1, 26'h10,    1, 32'h999,      0, 1, 32'h00000500, 32'h00000500, 1, 1, 1);

        // Reset held with irq high.
        reset   = 1'b0;
        bus.irq = 1'b1;
        rst_v = idle(32'h0);
        rst_v.e_wr = 0; rst_v.e_fif = 1; rst_v.e_fid = 1;
        for (int i = 0; i < 3; i++) step(rst_v, "reset");
        @(negedge clk);
        check_reg("reset", 32'h0, 2'b00);

        reset   = 1'b1;
        bus.irq = 1'b0;
        apply(idle(32'h0));
        check_out("release");

        for (int i = 0; i < 13; i++) step(tbl[i], $sformatf("vec%0d", i));
        @(negedge clk);
        check_reg("after_table", 32'h0, 2'b00);

        // Illegal op, then a held illop in the FLUSH slot is ignored.
        apply(mk(32'h44, 0, 32'h40, 0, 26'h0, 0, 32'h0, 1, 0, 32'h0, ILLOP, 1, 1, 1));
        check_out("illop");
        step(mk(32'h80000004, 0, 32'h44, 0, 26'h0, 0, 32'h0, 1, 0, 32'h0, 32'h80000008, 1, 0, 0),
             "illop_flush");
        check_reg("illop", 32'h40, 2'b01);
        step(idle(32'h80000008), "post_illop");
        check_reg("illop_held", 32'h40, 2'b01);

        // Interrupt in user mode: latency through synchronizer and pending flop.
        @(negedge clk);
        sb.delete();
        bus.id_illop = 1'b0;
        bus.pc       = 32'h200;
        bus.irq      = 1'b1;
        taken_at     = -1;
        for (int k = 0; k < 10; k++) begin
            #2;
            if (bus.pc_in === XADR) begin
                taken_at = k;
                break;
            end
            @(negedge clk);
        end
        chk("irq_latency", taken_at, SYNC + 1);
        chk("irq_flush_if", {31'd0, bus.flush_if}, 32'd1);
        chk("irq_flush_id", {31'd0, bus.flush_id}, 32'd0);
        @(negedge clk);
        check_reg("irq", 32'h200, 2'b10);
        bus.irq = 1'b0;
        for (int i = 0; i < 4; i++) step(idle(32'h200), "irq_low");

        // Interrupt while in kernel mode stays pending.
        @(negedge clk);
        bus.irq = 1'b1;
        for (int i = 0; i < 8; i++) step(idle(32'h80000200), "kernel_hold");
        check_reg("kernel_hold", 32'h200, 2'b10);
        step(mk(32'h300, 1, 32'h2FC, 0, 26'h0, 0, 32'h0, 0, 0, 32'h0, 32'h304, 0, 0, 1), "irq_stall");
        step(mk(32'h300, 0, 32'h2FC, 0, 26'h0, 0, 32'h0, 0, 0, 32'h0, XADR, 1, 1, 0), "irq_deferred");
        @(negedge clk);
        check_reg("irq_deferred", 32'h300, 2'b10);
        bus.irq = 1'b0;
        apply(idle(32'h80000008));
        check_out("irq_pend_cleared");

        // Reset while in FLUSH.
        step(mk(32'h60, 0, 32'h5C, 0, 26'h0, 0, 32'h0, 1, 0, 32'h0, ILLOP, 1, 1, 1), "illop2");
        @(negedge clk);
        reset = 1'b0;
        rst_v = idle(32'h60);
        rst_v.e_wr = 0; rst_v.e_fif = 1; rst_v.e_fid = 1;
        apply(rst_v);
        check_out("reset_mid_flush");
        @(negedge clk);
        check_reg("reset_mid_flush", 32'h0, 2'b00);
        reset = 1'b1;
        apply(mk(32'h74, 0, 32'h70, 0, 26'h0, 0, 32'h0, 1, 0, 32'h0, ILLOP, 1, 1, 1));
        check_out("illop_after_reset");
        @(negedge clk);
        check_reg("illop_after_reset", 32'h70, 2'b01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/pc_next_ctrl.md
Name: pc_next_ctrl

Overview:
- Next-PC and redirect controller for the pipelined processor. It is the writer side of the PC register and drives that register's PC_in/PCWr pair.
- Each cycle it picks sequential, jump, jr, branch, illegal-op or interrupt target. It holds the PC on stalls, raises IF/ID flushes and records EPC/cause on traps.
- Bit 31 of PC is the kernel-mode bit. It can only be set by trap entry.

Parameters:
ILLOP_ADDR, 32'h80000004, illegal-instruction vector
XADR_ADDR, 32'h80000008, interrupt vector
IRQ_SYNC, 2, irq synchronizer flop count (>=2)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low
pc  in  32  current PC register value (IF stage)
stall  in  1  load-use hazard; hold PC and IF/ID
id_pc  in  32  PC of instruction in ID
id_jump  in  1  J/JAL decoded in ID
id_jump_target  in  26  J-format target field
id_jr  in  1  JR/JALR decoded in ID
id_jr_addr  in  32  forwarded register value for jr
id_illop  in  1  undefined opcode in ID
ex_branch_taken  in  1  resolved taken branch in EX
ex_branch_target  in  32  branch target from EX
irq  in  1  asynchronous level interrupt request
pc_in  out  32  next PC value to PC register
pc_wr  out  1  PC write enable
flush_if  out  1  bubble IF/ID register
flush_id  out  1  bubble ID/EX register
epc  out  32  exception return address (registered)
exc_cause  out  2  00 none, 01 illop, 10 irq (registered)

Behaviour:
- Reset is synchronous and active-low; clock is clk.
- While reset=0:
  - pc_wr=0, flush_if=1, flush_id=1, pc_in=pc+4 form.
  - Registers clear: epc=0, exc_cause=00, irq_pend=0, sync flops=0, state=RUN.
- irq path:
  - irq passes an IRQ_SYNC-stage synchronizer, then a rising-edge detect sets irq_pend.
  - irq_pend clears only in the cycle the interrupt is taken.
  - Edge and take in the same cycle: take wins, then the bit is re-set next cycle only on a new edge.
- States: RUN, FLUSH. FLUSH lasts exactly one cycle after any trap, then returns to RUN. In FLUSH, id_illop and irq_pend are ignored because the ID slot is a bubble; redirects and stall act normally.
- seq = {pc[31], pc[30:0]+4}. Bit 31 is preserved; the low 31 bits wrap 7FFFFFFC→0.
- Priority, highest first; pc_wr=1 unless stated:
  1. ex_branch_taken: pc_in={pc[31], ex_branch_target[30:0]}, flush_if=1, flush_id=1. An illop/jump in ID is squashed.
  2. id_illop (state RUN): pc_in=ILLOP_ADDR, flush_if=1, flush_id=1, epc<=id_pc, exc_cause<=01, state<=FLUSH. Taken in either mode.
  3. irq_pend & ~pc[31] & state RUN & ~stall & ~id_jump & ~id_jr: pc_in=XADR_ADDR, flush_if=1, flush_id=0, epc<=pc, exc_cause<=10, irq_pend<=0, state<=FLUSH. The instruction in ID completes normally.
  4. id_jump & ~stall: pc_in={id_pc[31:28], id_jump_target, 2'b00}, flush_if=1.
  5. id_jr & ~stall: pc_in={pc[31] & id_jr_addr[31], id_jr_addr[30:0]}, flush_if=1. User code cannot enter kernel via jr; kernel jr may clear bit 31.
  6. stall: pc_wr=0, flush_if=0, flush_id=1 (bubble into EX), pc_in=seq.
  7. otherwise: pc_in=seq, no flush.
- Outputs pc_in, pc_wr, flush_* are combinational. epc and exc_cause are registered and update on the trap edge.
- Stall together with a jump/jr: the jump waits for the stall to clear (rule 6 applies).
- Interrupt deferral: while in kernel mode the interrupt stays pending and is taken on the first eligible RUN cycle after pc[31] returns to 0.
- Reset mid-FLUSH returns to RUN with all registers cleared.

Test Plan:
- Reset: hold reset=0 for 3 cycles with irq=1 → pc_wr=0, flush_if=flush_id=1, epc=0, exc_cause=0. Release with pc=0 → pc_in=4, pc_wr=1.
- Sequential/wrap: pc=0x7FFFFFFC → pc_in=0x00000000; pc=0x80000010 → pc_in=0x80000014.
- Branch beats illop: ex_branch_taken=1, target=0x00000100, id_illop=1 → pc_in=0x100, both flushes set, exc_cause unchanged.
- Illop: id_pc=0x40, id_illop=1 → pc_in=0x80000004, epc=0x40 next cycle, exc_cause=01. A second id_illop held high the next cycle is ignored (FLUSH state).
- Interrupt: irq rises with pc=0x200 → taken IRQ_SYNC+1 cycles later with pc_in=0x80000008 and epc=that cycle's pc. Same test with pc=0x80000200 → no trap; taken later once pc=0x300.
- Stall/jr: stall=1 with id_jr=1 → pc_wr=0, flush_id=1. Then stall=0, id_jr_addr=0x80001000, pc=0x50 → pc_in=0x00001000, flush_if=1.
